// File: rtl/xorn_parity_pkg.sv
// Shared types and constants for the xorn_parity_accum frame parity stage.
// Optional parity check is enabled by defining XORN_PARITY_CHECK_EN.
package xorn_parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Implementation styles for xorn_reduce.
  localparam int RED_EQN  = 0;
  localparam int RED_BEH  = 1;
  localparam int RED_PRIM = 2;

endpackage

// File: rtl/xorn_reduce.sv
// WIDTH-input XOR reduction; IMPL picks equation, behavioural loop,
// or a chain of xor primitives. All three are purely combinational.
module xorn_reduce
  import xorn_parity_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IMPL  = RED_EQN
)(
  input  logic [WIDTH-1:0] data,
  output logic             par
);

  generate
    if (IMPL == RED_PRIM) begin : g_prim
      logic [WIDTH-1:0] chain;
      assign chain[0] = data[0];
      for (genvar i = 1; i < WIDTH; i++) begin : g_x
        xor u_x (chain[i], chain[i-1], data[i]);
      end
      assign par = chain[WIDTH-1];
    end else if (IMPL == RED_BEH) begin : g_beh
      always_comb begin
        par = 1'b0;
        for (int i = 0; i < WIDTH; i++)
          par = par ^ data[i];
      end
    end else begin : g_eqn
      assign par = ^data;
    end
  endgenerate

endmodule

// File: rtl/xorn_parity_accum.sv
// Frame parity accumulator with valid/ready result hold.
// Define XORN_PARITY_CHECK_EN to add i_exp_parity / o_par_err.
module xorn_parity_accum
  import xorn_parity_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int MAX_WORDS = 16,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  input  logic             i_odd,
  output logic             o_ready,
  output logic             o_par_valid,
  input  logic             i_par_ready,
  output logic             o_parity,
  output logic [CNT_W-1:0] o_word_cnt,
`ifdef XORN_PARITY_CHECK_EN
  input  logic             i_exp_parity,
  output logic             o_par_err,
`endif
  output logic             o_overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t           state, state_nx;
  logic             acc, mode, ovf;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             w, acc_nx;
  logic             accept, hold, full;

  xorn_reduce #(
    .WIDTH (WIDTH),
    .IMPL  (RED_EQN)
  ) u_reduce (
    .data (i_data),
    .par  (w)
  );

  assign hold   = (state == HOLD);
  assign accept = i_valid & ~hold;
  assign cnt_nx = (state == IDLE) ? CNT_W'(1) : cnt + 1'b1;
  assign acc_nx = (state == IDLE) ? w : acc ^ w;
  assign full   = (cnt_nx == MAX_CNT);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (accept)
          state_nx = (i_last | full) ? HOLD : ACCUM;
      end
      HOLD: begin
        if (i_par_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      acc   <= 1'b0;
      mode  <= PAR_EVEN;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
        ovf <= full & ~i_last;
        if (state == IDLE)
          mode <= i_odd;
      end else if (hold && i_par_ready) begin
        acc  <= 1'b0;
        mode <= PAR_EVEN;
        cnt  <= '0;
        ovf  <= 1'b0;
      end
    end
  end

  assign o_ready     = ~hold;
  assign o_par_valid = hold;
  assign o_parity    = hold & (acc ^ mode);
  assign o_word_cnt  = hold ? cnt : '0;
  assign o_overflow  = hold & ovf;

`ifdef XORN_PARITY_CHECK_EN
  // Expectation only exists when the frame closed on i_last.
  logic exp_par, exp_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      exp_par <= 1'b0;
      exp_vld <= 1'b0;
    end else if (accept) begin
      exp_par <= i_last & i_exp_parity;
      exp_vld <= i_last;
    end else if (hold && i_par_ready) begin
      exp_par <= 1'b0;
      exp_vld <= 1'b0;
    end
  end

  assign o_par_err = hold & exp_vld & (o_parity != exp_par);
`endif

endmodule

// File: tb/tb_xorn_parity_accum.sv
// Directed scoreboard bench for xorn_parity_accum.
// Parity-check ports are exercised when XORN_PARITY_CHECK_EN is defined.
module tb_xorn_parity_accum;

  localparam int WIDTH = 4;
  localparam int MAXW  = 16;
  localparam int CW    = $clog2(MAXW + 1);

  typedef struct {
    logic          par;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          err;
  } exp_t;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_last = 1'b0;
  logic             i_odd = 1'b0;
  logic             o_ready;
  logic             o_par_valid;
  logic             i_par_ready = 1'b0;
  logic             o_parity;
  logic [CW-1:0]    o_word_cnt;
  logic             o_overflow;
  logic             i_exp_parity = 1'b0;
`ifdef XORN_PARITY_CHECK_EN
  logic             o_par_err;
`endif

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  // Reference model state
  int   m_cnt  = 0;
  logic m_acc  = 1'b0;
  logic m_mode = 1'b0;

  always #5 i_clk = ~i_clk;

  xorn_parity_accum #(
    .WIDTH     (WIDTH),
    .MAX_WORDS (MAXW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_last       (i_last),
    .i_odd        (i_odd),
    .o_ready      (o_ready),
    .o_par_valid  (o_par_valid),
    .i_par_ready  (i_par_ready),
    .o_parity     (o_parity),
    .o_word_cnt   (o_word_cnt),
`ifdef XORN_PARITY_CHECK_EN
    .i_exp_parity (i_exp_parity),
    .o_par_err    (o_par_err),
`endif
    .o_overflow   (o_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] d, input logic l,
                       input logic odd, input logic e);
    int   n;
    logic closes;
    exp_t x;
    n = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    i_odd   = odd;
    i_exp_parity = e;
    while (!o_ready && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (m_cnt == 0) begin
      m_mode = odd;
      m_acc  = ^d;
    end else begin
      m_acc = m_acc ^ (^d);
    end
    m_cnt++;
    closes = l || (m_cnt == MAXW);
    if (closes) begin
      x.par = m_acc ^ m_mode;
      x.cnt = CW'(m_cnt);
      x.ovf = !l;
      x.err = l && (x.par != e);
      sb.push_back(x);
      m_cnt = 0;
      m_acc = 1'b0;
    end
    chk("latency_valid", o_par_valid, closes);
  endtask

  task automatic collect(input string tag, input int hold_cyc);
    int   n;
    exp_t x;
    n = 0;
    while (!o_par_valid && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, o_par_valid, 1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
      return;
    end
    x = sb.pop_front();
    for (int i = 0; i < hold_cyc; i++) begin
      @(posedge i_clk);
      #1;
      chk({tag, "_bp_ready"}, o_ready, 0);
      chk({tag, "_bp_par"}, o_parity, x.par);
      chk({tag, "_bp_cnt"}, o_word_cnt, x.cnt);
    end
    chk({tag, "_parity"}, o_parity, x.par);
    chk({tag, "_cnt"}, o_word_cnt, x.cnt);
    chk({tag, "_ovf"}, o_overflow, x.ovf);
`ifdef XORN_PARITY_CHECK_EN
    chk({tag, "_err"}, o_par_err, x.err);
`endif
    i_par_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_par_ready = 1'b0;
    chk({tag, "_rel_valid"}, o_par_valid, 0);
    chk({tag, "_rel_ready"}, o_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_par_valid, 0);
    chk("rst_parity", o_parity, 0);
    chk("rst_cnt", o_word_cnt, 0);
    chk("rst_ovf", o_overflow, 0);

    // i_par_ready outside HOLD has no effect
    i_par_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_par_ready = 1'b0;
    chk("idle_prdy_ready", o_ready, 1);
    chk("idle_prdy_valid", o_par_valid, 0);

    // Even frame, 6 ones, with 5 cycles of backpressure
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    drive(4'b0011, 1'b0, 1'b0, 1'b0);
    drive(4'b0111, 1'b1, 1'b0, 1'b0);
    collect("even3", 5);

    // Odd frame; i_odd toggled after first word is ignored
    drive(4'b0001, 1'b0, 1'b1, 1'b0);
    drive(4'b0011, 1'b0, 1'b0, 1'b0);
    drive(4'b0111, 1'b1, 1'b0, 1'b0);
    collect("odd3", 0);

    // Forced close at MAX_WORDS
    for (int i = 0; i < MAXW; i++)
      drive(4'b0001, 1'b0, 1'b0, 1'b0);
    i_valid = 1'b1;
    i_data  = 4'b0001;
    repeat (2) @(posedge i_clk);
    #1;
    chk("ovf_17th_ready", o_ready, 0);
    chk("ovf_17th_cnt", o_word_cnt, MAXW);
    i_valid = 1'b0;
    collect("ovf", 0);

    // i_last on the MAX_WORDS-th word is a normal close
    for (int i = 0; i < MAXW - 1; i++)
      drive(4'b0011, 1'b0, 1'b1, 1'b0);
    drive(4'b0111, 1'b1, 1'b0, 1'b1);
    collect("max_last", 0);

    // Reset mid-frame discards it
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    drive(4'b0011, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    m_cnt = 0;
    m_acc = 1'b0;
    chk("mid_rst_ready", o_ready, 1);
    chk("mid_rst_valid", o_par_valid, 0);
    chk("mid_rst_parity", o_parity, 0);
    chk("mid_rst_cnt", o_word_cnt, 0);
    chk("mid_rst_ovf", o_overflow, 0);

    drive(4'b1000, 1'b1, 1'b0, 1'b0);
    collect("single", 0);

    // Expectation check: parity 1 vs expected 0 then 1
    drive(4'b1111, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 1'b0);
    collect("chk_e0", 0);
    drive(4'b1111, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 1'b1);
    collect("chk_e1", 0);

    // Reset while holding a result
    drive(4'b0101, 1'b1, 1'b1, 1'b0);
    chk("hold_rst_pre", o_par_valid, 1);
    void'(sb.pop_front());
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("hold_rst_valid", o_par_valid, 0);
    chk("hold_rst_parity", o_parity, 0);
    chk("hold_rst_ready", o_ready, 1);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xorn_parity_accum.md
Name: xorn_parity_accum

Overview:
- Sequential successor to the fixed 4-input XOR gate. Generalised to a WIDTH-bit word.
- Accumulates XOR parity over a multi-word frame and selects even or odd parity per frame.
- Holds each frame result under a valid/ready handshake.
- Sits in the datapath-components library as the parity stage ahead of serial/packet checkers.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- MAX_WORDS, 16, maximum words per frame before forced termination (>=1).
- CNT_W, $clog2(MAX_WORDS+1), localparam, width of word counter.

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  input word present
- i_data  in  WIDTH  input word
- i_last  in  1  final word of frame, qualified by i_valid
- i_odd  in  1  parity mode, 1=odd, 0=even; sampled on first word of frame
- o_ready  out  1  block accepts a word this cycle
- o_par_valid  out  1  frame result available
- i_par_ready  in  1  downstream consumes result
- o_parity  out  1  frame parity bit
- o_word_cnt  out  CNT_W  words accepted in the reported frame
- o_overflow  out  1  frame force-closed at MAX_WORDS without i_last

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous, active-high.
- Reset values:
  - state=IDLE, o_ready=1, o_par_valid=0, o_parity=0, o_word_cnt=0, o_overflow=0.
  - Internal accumulator=0 and count=0.
- Word accept: occurs when i_valid & o_ready at a rising edge.
- Word parity: w = XOR-reduce(i_data).
- IDLE (o_ready=1):
  - On accept: latch mode=i_odd, acc=w, cnt=1.
  - If i_last: go to HOLD; otherwise go to ACCUM.
- ACCUM (o_ready=1):
  - On accept: acc^=w, cnt+=1.
  - If i_last, or the new cnt==MAX_WORDS: go to HOLD.
  - Overflow flag is set when cnt reaches MAX_WORDS with i_last=0.
  - i_odd is ignored in ACCUM.
- HOLD (o_ready=0, o_par_valid=1):
  - o_parity = acc ^ mode. Even mode gives 0 when the total count of ones is even.
  - o_word_cnt=cnt; o_overflow as flagged.
  - Outputs stay stable until i_par_ready=1.
  - On i_par_ready: next cycle return to IDLE, clear acc/cnt/flag, o_par_valid=0, o_ready=1.
  - No bypass: one idle-ready cycle separates frames.
- Latency: result registered and visible the cycle after the final word is accepted.
- Single-word frame (i_last on first word): valid result with o_word_cnt=1.
- MAX_WORDS=1: every frame closes after one word. Overflow only if i_last=0.
- i_last together with cnt reaching MAX_WORDS: normal close, o_overflow=0.
- i_valid while o_ready=0: word not accepted; no state change. Upstream must hold the word.
- i_par_ready while not in HOLD: ignored.
- Reset mid-frame or in HOLD: frame discarded; all outputs return to reset values next cycle.
- Data X-free requirement applies only to accepted words.

Optional Feature:
- Macro: XORN_PARITY_CHECK_EN.
- With the macro:
  - Adds input i_exp_parity (1), sampled with the accepted i_last word.
  - Adds output o_par_err (1): valid in HOLD, equals o_parity != sampled expectation.
  - o_par_err is 0 on overflow close, when no expectation was sampled. Reset value 0.
- Without the macro: both ports and the logic are absent; all other behaviour is identical.

Decomposition:
- Package xorn_parity_pkg:
  - state enum with IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2.
  - Mode constants PAR_EVEN=1'b0, PAR_ODD=1'b1.
- One natural sub-module, xorn_reduce: combinational WIDTH-input XOR reduction.
  - Parametrised on WIDTH.
  - Replaces the fixed 4-input gate; its equation, behavioural and primitive variants are selectable.

Test Plan:
- Reset, then a single frame:
  - Words 4'b0001, 4'b0011, 4'b0111 (last), i_odd=0 -> HOLD the cycle after the last word.
  - Expected outputs: o_parity=0 (6 ones), o_word_cnt=3, o_overflow=0.
- Same three words with i_odd=1 on the first word:
  - o_parity=1.
  - Toggling i_odd mid-frame has no effect.
- Overflow (MAX_WORDS=16):
  - Feed 16 words 4'b0001 with i_last=0 -> force close with o_overflow=1, o_word_cnt=16, o_parity=0.
  - The 17th word is not accepted while o_ready=0.
- Backpressure:
  - Hold i_par_ready=0 for 5 cycles in HOLD -> outputs stable and o_ready=0 throughout.
  - Assert i_par_ready -> IDLE next cycle and the next frame is accepted.
- Reset mid-frame:
  - Assert i_rst after 2 of 3 words -> all outputs at reset values.
  - A new single-word frame 4'b1000 (last), even mode -> o_parity=1, o_word_cnt=1.
- With XORN_PARITY_CHECK_EN:
  - Frame with words 4'b1111 and 4'b0001 (last), even mode, i_exp_parity=0 -> o_parity=1, o_par_err=1.
  - Repeat with i_exp_parity=1 -> o_par_err=0.
